alu_seq_ctrl: RTL
=================

# alu_seq_ctrl

Sequencing controller for the 6-bit ALU datapath. It accepts one operation request at a time through a START/READY handshake and latches the operands and opcode. It drives the select of the conditional-inverter stage for subtract, compare and invert operations, and runs single-cycle operations or a multi-cycle shift-add multiply. It returns a registered result, flags and a one-cycle DONE pulse. It sits between the board-level operand/opcode inputs and the result display logic.

## Interface

- WIDTH, 6, datapath width; multiply iteration count equals WIDTH.

- CLK  in  1  single system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  request; sampled only while READY=1.
- OP  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOTB, 110 MUL, 111 CMP.
- A  in  WIDTH  operand A, latched on acceptance.
- B  in  WIDTH  operand B, latched on acceptance.
- READY  out  1  high in IDLE only.
- DONE  out  1  one-cycle pulse when RESULT and flags update.
- RESULT  out  WIDTH  registered result, held until the next completion.
- CARRY  out  1  carry or no-borrow; for MUL, product exceeded WIDTH bits.
- OVF  out  1  signed two's-complement overflow (ADD/SUB/CMP only).
- ZERO  out  1  computed value equals 0.
- INV_SEL  out  1  select driven to the conditional-inverter stage; high means B is inverted.

## Operation

- States: IDLE, EXEC, MUL, DONE.
- **IDLE**
  - READY=1.
  - START=1 at a clock edge: latch A, B and OP into internal registers, then go to EXEC.
- **EXEC**
  - INV_SEL=1 for SUB, CMP and NOTB; otherwise 0.
  - Adder computes Areg + Binv + cin, where cin=1 for SUB and CMP.
  - ADD/SUB:
    - RESULT = sum mod 2^WIDTH.
    - CARRY = adder carry-out.
    - OVF = (Areg[msb]==Binv[msb]) && (sum[msb]!=Areg[msb]).
  - AND/OR/XOR: bitwise result on Areg and Breg; CARRY=0, OVF=0.
  - NOTB: RESULT = ~Breg, taken through the inverter stage; CARRY=0, OVF=0.
  - CMP:
    - Computes the SUB flags.
    - RESULT is not written and keeps its previous value.
    - ZERO reflects the difference.
  - ZERO = (computed value == 0) for all operations.
  - Non-MUL: registers update at the end of EXEC, then go to DONE.
  - MUL: clear the 2*WIDTH-bit accumulator and the iteration counter, then go to MUL.
- **MUL**
  - INV_SEL=0.
  - Each cycle: if Breg[cnt]=1, acc += Areg << cnt; then cnt++.
  - After WIDTH iterations:
    - RESULT = acc[WIDTH-1:0].
    - CARRY = |acc[2*WIDTH-1:WIDTH].
    - OVF = 0, ZERO = (RESULT == 0).
    - Go to DONE.
- **DONE**
  - DONE=1 for exactly one cycle; READY=0.
  - Next state is IDLE.
- START is ignored outside IDLE. Operand or opcode changes after acceptance have no effect.
- START held high: a new operation is accepted on every return to IDLE.

## Timing

- Reset values:
  - State IDLE.
  - READY=1, DONE=0, INV_SEL=0.
  - RESULT=0, CARRY=0, OVF=0, ZERO=0.
  - Internal registers 0.
- Latency, with START sampled at edge 0:
  - Non-MUL: EXEC is cycle 1, DONE is high in cycle 2, READY returns in cycle 3.
  - MUL: EXEC is cycle 1, MUL runs cycles 2 to 1+WIDTH, DONE is high in cycle 2+WIDTH (cycle 8 at WIDTH=6).
- Throughput: one non-MUL operation per 3 cycles; one MUL per WIDTH+3 cycles.
- INV_SEL is registered from the state and the latched OP. It is valid for the whole EXEC cycle and 0 in every other state.
- RESULT and flags change only in the cycle DONE rises, and are stable until the next DONE.
- RST_N asserted mid-operation:
  - All outputs and state take their reset values immediately, asynchronously.
  - The aborted operation never produces DONE.
  - The first START after release is accepted normally.

## Test plan

- ADD, A=25, B=40 -> RESULT=1, CARRY=1, OVF=0, ZERO=0, DONE exactly 2 cycles after the START edge, INV_SEL=0 throughout.
- SUB, A=5, B=5 -> RESULT=0, ZERO=1, CARRY=1, INV_SEL=1 in EXEC. Then SUB, A=3, B=5 -> RESULT=62, CARRY=0, OVF=0.
- SUB, A=31, B=32 -> RESULT=63, OVF=1, CARRY=0. Then CMP, A=9, B=9 -> ZERO=1, CARRY=1, RESULT stays 63.
- MUL, A=7, B=9 -> RESULT=63, CARRY=0, DONE in cycle 8. Then MUL, A=12, B=10 -> RESULT=56, CARRY=1.
- NOTB, B=6'b000101 -> RESULT=6'b111010. START pulsed during EXEC/MUL is ignored. A and B changed after acceptance do not change RESULT.
- MUL started, RST_N low in cycle 4 -> all outputs at reset values the same cycle and no DONE. After release, ADD 1+1 -> RESULT=2. START held high -> accepted again every 3 cycles.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for the 6-bit ALU datapath: START/READY handshake,
// single-cycle ALU ops, shift-add multiply, registered result/flags and DONE pulse.
module alu_seq_ctrl #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             READY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             CARRY,
  output logic             OVF,
  output logic             ZERO,
  output logic             INV_SEL
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOTB = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_CMP  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [2:0]           op_q, op_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
  logic                 inv_sel_q, inv_sel_d;

  logic [WIDTH-1:0]     binv;
  logic                 cin;
  logic [WIDTH:0]       sum_w;
  logic [2*WIDTH-1:0]   acc_add, acc_nxt;
  logic [WIDTH-1:0]     exec_val;
  logic                 exec_c, exec_o;

  always_comb begin
    binv    = inv_sel_q ? ~b_q : b_q;
    cin     = (op_q == OP_SUB) || (op_q == OP_CMP);
    sum_w   = {1'b0, a_q} + {1'b0, binv} + {{WIDTH{1'b0}}, cin};
    acc_add = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
    acc_nxt = acc_q + acc_add;

    exec_val = '0;
    exec_c   = 1'b0;
    exec_o   = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB, OP_CMP: begin
        exec_val = sum_w[WIDTH-1:0];
        exec_c   = sum_w[WIDTH];
        exec_o   = (a_q[WIDTH-1] == binv[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND:  exec_val = a_q & b_q;
      OP_OR:   exec_val = a_q | b_q;
      OP_XOR:  exec_val = a_q ^ b_q;
      OP_NOTB: exec_val = binv;
      default: exec_val = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    inv_sel_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          a_d       = A;
          b_d       = B;
          op_d      = OP;
          // registered here so the inverter select is valid for the whole EXEC cycle
          inv_sel_d = (OP == OP_SUB) || (OP == OP_CMP) || (OP == OP_NOTB);
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_q == OP_MUL) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_MUL;
        end else begin
          if (op_q != OP_CMP) result_d = exec_val;
          carry_d = exec_c;
          ovf_d   = exec_o;
          zero_d  = (exec_val == '0);
          state_d = S_DONE;
        end
      end
      S_MUL: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          result_d = acc_nxt[WIDTH-1:0];
          carry_d  = |acc_nxt[2*WIDTH-1:WIDTH];
          ovf_d    = 1'b0;
          zero_d   = (acc_nxt[WIDTH-1:0] == '0);
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      inv_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
      inv_sel_q <= inv_sel_d;
    end
  end

  assign READY   = (state_q == S_IDLE);
  assign DONE    = (state_q == S_DONE);
  assign RESULT  = result_q;
  assign CARRY   = carry_q;
  assign OVF     = ovf_q;
  assign ZERO    = zero_q;
  assign INV_SEL = inv_sel_q;

endmodule
